// File: rtl/apb_i2c_pkg.sv
// rtl/apb_i2c_pkg.sv - shared widths, defaults and state encoding for the APB-to-I2C bridge
package apb_i2c_pkg;

  localparam int ADDR_W                 = 8;
  localparam int DATA_W                 = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/bridge_timeout.sv
// rtl/bridge_timeout.sv - saturating cycle counter that flags an I2C transfer running too long
module bridge_timeout #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [W-1:0] count;

  // Holds at the terminal count so expired stays asserted until cleared
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(CYCLES - 1));

endmodule

// File: rtl/apb_i2c_bridge.sv
// rtl/apb_i2c_bridge.sv - APB slave that turns each access into one request/acknowledge I2C master transfer
module apb_i2c_bridge
  import apb_i2c_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              i2c_ce,
  output logic              i2c_rden,
  output logic              i2c_wren,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [DATA_W-1:0] i2c_wdata,
  input  logic [DATA_W-1:0] i2c_rdata,
  input  logic              i2c_ready,
  input  logic              i2c_error
);

  bridge_state_e     state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] prdata_q;
  logic              write_q;
  logic              err_q;
  logic              busy;
  logic              expired;
  logic              capture;
  logic              capture_err;

  assign busy = (state == ISSUE) || (state == WAIT);

  bridge_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // ISSUE waits for a stale ready level to clear so a leftover ack is never taken as completion
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    capture_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && penable) state_next = ISSUE;
      end
      ISSUE: begin
        if (expired) begin
          state_next  = RESP;
          capture     = 1'b1;
          capture_err = 1'b1;
        end else if (!i2c_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i2c_ready) begin
          state_next  = RESP;
          capture     = 1'b1;
          capture_err = i2c_error;
        end else if (expired) begin
          state_next  = RESP;
          capture     = 1'b1;
          capture_err = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && psel && penable) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        write_q <= pwrite;
      end
      if (capture) begin
        err_q    <= capture_err;
        prdata_q <= (!write_q && !capture_err) ? i2c_rdata : '0;
      end
    end
  end

  assign i2c_ce    = busy;
  assign i2c_rden  = busy && !write_q;
  assign i2c_wren  = busy && write_q;
  assign i2c_addr  = addr_q;
  assign i2c_wdata = wdata_q;
  assign pready    = (state == RESP);
  assign pslverr   = (state == RESP) && err_q;
  assign prdata    = prdata_q;

endmodule

// File: tb/tb_apb_i2c_bridge.sv
// tb/tb_apb_i2c_bridge.sv - directed scoreboard bench for apb_i2c_bridge
module tb_apb_i2c_bridge;

  typedef struct packed {
    logic [7:0] prdata;
    logic       pslverr;
  } resp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic       i2c_ce, i2c_rden, i2c_wren;
  logic [7:0] i2c_addr, i2c_wdata, i2c_rdata;
  logic       i2c_ready, i2c_error;

  logic       t_psel, t_penable, t_pwrite;
  logic [7:0] t_paddr, t_pwdata, t_prdata;
  logic       t_pready, t_pslverr;
  logic       t_ce, t_rden, t_wren;
  logic [7:0] t_addr, t_wdata, t_rdata;
  logic       t_ready, t_error;

  int    n_checks = 0;
  int    n_fail   = 0;
  resp_t exp_q[$];

  always #5 clk = ~clk;

  apb_i2c_bridge dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .i2c_ce(i2c_ce), .i2c_rden(i2c_rden), .i2c_wren(i2c_wren), .i2c_addr(i2c_addr),
    .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_ready(i2c_ready), .i2c_error(i2c_error)
  );

  apb_i2c_bridge #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .reset(reset), .psel(t_psel), .penable(t_penable), .pwrite(t_pwrite),
    .paddr(t_paddr), .pwdata(t_pwdata), .prdata(t_prdata), .pready(t_pready), .pslverr(t_pslverr),
    .i2c_ce(t_ce), .i2c_rden(t_rden), .i2c_wren(t_wren), .i2c_addr(t_addr),
    .i2c_wdata(t_wdata), .i2c_rdata(t_rdata), .i2c_ready(t_ready), .i2c_error(t_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic [7:0] prd, input logic slv);
    resp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_prdata", prd, e.prdata);
      chk("sb_pslverr", slv, e.pslverr);
    end
  endtask

  task automatic apb_start(input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    chk("setup_phase_no_ce", i2c_ce, 0);
    penable = 1'b1;
    @(negedge clk);
    chk("ce_rise", i2c_ce, 1);
    chk("rden", i2c_rden, !wr);
    chk("wren", i2c_wren, wr);
    chk("i2c_addr", i2c_addr, a);
    chk("i2c_wdata", i2c_wdata, d);
  endtask

  task automatic finish_ready(input logic [7:0] rd, input logic err);
    i2c_ready = 1'b1; i2c_rdata = rd; i2c_error = err;
    @(negedge clk);
    chk("pready_latency", pready, 1);
    chk("ce_drop", i2c_ce, 0);
    chk("req_idle", {i2c_rden, i2c_wren}, 0);
    pop_chk(prdata, pslverr);
    i2c_ready = 1'b0; i2c_error = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("pready_one_cycle", pready, 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    i2c_rdata = 0; i2c_ready = 0; i2c_error = 0;
    t_psel = 0; t_penable = 0; t_pwrite = 0; t_paddr = 0; t_pwdata = 0;
    t_rdata = 0; t_ready = 0; t_error = 0;
    repeat (3) @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_ce_rd_wr", {i2c_ce, i2c_rden, i2c_wren}, 0);
    chk("rst_addr_wdata", {i2c_addr, i2c_wdata}, 0);
    reset = 1'b0;

    // Read 0x41, ready pulse after 40 cycles
    exp_q.push_back('{prdata: 8'h05, pslverr: 1'b0});
    apb_start(1'b0, 8'h41, 8'h00);
    repeat (40) @(negedge clk);
    chk("rd_ce_held", i2c_ce, 1);
    chk("rd_no_early_pready", pready, 0);
    chk("rd_addr_stable", i2c_addr, 8'h41);
    finish_ready(8'h05, 1'b0);
    chk("prdata_hold", prdata, 8'h05);

    // Write 0x41 <- 0x5F; rdata bus is deliberately non-zero
    exp_q.push_back('{prdata: 8'h00, pslverr: 1'b0});
    apb_start(1'b1, 8'h41, 8'h5F);
    repeat (10) @(negedge clk);
    chk("wr_ce_held", i2c_ce, 1);
    chk("wr_wdata_stable", i2c_wdata, 8'h5F);
    finish_ready(8'h99, 1'b0);

    // Read completing with NACK
    exp_q.push_back('{prdata: 8'h00, pslverr: 1'b1});
    apb_start(1'b0, 8'h82, 8'h00);
    repeat (3) @(negedge clk);
    finish_ready(8'h77, 1'b1);

    // Error without ready is ignored
    exp_q.push_back('{prdata: 8'h3C, pslverr: 1'b0});
    apb_start(1'b0, 8'h13, 8'h00);
    repeat (2) @(negedge clk);
    i2c_error = 1'b1;
    @(negedge clk);
    chk("err_only_no_pready", pready, 0);
    chk("err_only_ce_held", i2c_ce, 1);
    i2c_error = 1'b0;
    @(negedge clk);
    finish_ready(8'h3C, 1'b0);

    // Stale ready level held into the next access
    exp_q.push_back('{prdata: 8'h11, pslverr: 1'b0});
    i2c_ready = 1'b1; i2c_rdata = 8'hEE;
    apb_start(1'b0, 8'hC2, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stale_no_pready", pready, 0);
      chk("stale_ce_held", i2c_ce, 1);
    end
    i2c_ready = 1'b0;
    repeat (2) @(negedge clk);
    finish_ready(8'h11, 1'b0);

    // psel dropped mid-transfer: transfer still completes
    exp_q.push_back('{prdata: 8'h00, pslverr: 1'b0});
    apb_start(1'b1, 8'h07, 8'hA3);
    psel = 1'b0; penable = 1'b0;
    repeat (4) @(negedge clk);
    chk("drop_ce_held", i2c_ce, 1);
    finish_ready(8'h00, 1'b0);
    chk("drop_no_new_xfer", i2c_ce, 0);

    // Reset during WAIT
    apb_start(1'b0, 8'h55, 8'h00);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ce", i2c_ce, 0);
    chk("rst_mid_pready", pready, 0);
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_pready", pready, 0);
    end
    exp_q.push_back('{prdata: 8'hA5, pslverr: 1'b0});
    apb_start(1'b0, 8'h80, 8'h00);
    repeat (4) @(negedge clk);
    finish_ready(8'hA5, 1'b0);

    // Timeout with TIMEOUT_CYCLES=16, ready never asserted
    exp_q.push_back('{prdata: 8'h00, pslverr: 1'b1});
    @(negedge clk);
    t_psel = 1'b1; t_pwrite = 1'b0; t_paddr = 8'h10;
    @(negedge clk);
    t_penable = 1'b1;
    @(negedge clk);
    chk("to_ce_rise", t_ce, 1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (t_pready && k == 0) k = i;
      if (k != 0) break;
    end
    chk("to_latency", k, 16);
    chk("to_ce_drop", t_ce, 0);
    pop_chk(t_prdata, t_pslverr);
    t_psel = 1'b0; t_penable = 1'b0;
    @(negedge clk);
    chk("to_pready_one_cycle", t_pready, 0);
    chk("to_ce_idle", t_ce, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
